// File: rtl/sata_hcomfsm.sv
// sata_hcomfsm
// Host-side SATA OOB (COM) handshake sequencer. The host sends COMRESET,
// waits for the device to answer with COMINIT, sends COMWAKE, then waits for
// the device COMWAKE to start and finish. After that it hands the serial TX
// stream to the link layer. If a wait stalls, the whole handshake is retried.
//
// Ports
//   i_clk           TX bit clock, one serial bit per cycle
//   i_reset_n       asynchronous active-low reset (released synchronously)
//   i_comreset_req  one-cycle request to restart the handshake from any state
//   i_cominit_det   asynchronous level, device COMINIT present on the line
//   i_comwake_det   asynchronous level, device COMWAKE present on the line
//   i_tx            link-layer TX bit, forwarded only while ACTIVE
//   o_tx            serial TX bit (0 whenever the line is idle)
//   o_tx_idle       1 = electrical idle
//   o_link_ready    1 while ACTIVE
//   o_state         current handshake state (IDLE=0 .. ACTIVE=6)
//   o_retry         one-cycle pulse when a wait timed out and a retry began
//   o_retries       number of timeout retries, saturating at 15
module sata_hcomfsm #(
  parameter real CLOCK_SYM_NS = 1000.0 / 1500.0,
  parameter int  NUM_COMRESET = 6,
  parameter int  NUM_COMWAKE  = 6,
  // The 0.5 rounds the ns-to-cycles conversion. A truncating conversion could
  // land one cycle short when the reciprocal clock period is not exact.
  parameter int  RESET_IDLES  = $rtoi(320.0 / CLOCK_SYM_NS + 0.5),
  parameter int  WAKE_IDLES   = $rtoi(106.7 / CLOCK_SYM_NS + 0.5),
  parameter int  TIMEOUT      = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_comreset_req,
  input  logic       i_cominit_det,
  input  logic       i_comwake_det,
  input  logic       i_tx,
  output logic       o_tx,
  output logic       o_tx_idle,
  output logic       o_link_ready,
  output logic [2:0] o_state,
  output logic       o_retry,
  output logic [3:0] o_retries
);

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_SEND_COMRESET = 3'd1,
    ST_WAIT_COMINIT  = 3'd2,
    ST_SEND_COMWAKE  = 3'd3,
    ST_WAIT_COMWAKE  = 3'd4,
    ST_WAIT_RELEASE  = 3'd5,
    ST_ACTIVE        = 3'd6
  } state_t;

  // One burst is four back-to-back copies of {D, ~D, D, ~D}, sent MSB first.
  localparam int BURST_BITS = 160;
  localparam logic [9:0]  COM_D   = 10'b1100110011;
  localparam logic [39:0] COM_SEQ = {COM_D, ~COM_D, COM_D, ~COM_D};
  localparam logic [5:0]  SEQ_LAST = 6'd39;

  // A slot is one burst followed by its idle gap.
  localparam int RESET_SLOT = BURST_BITS + RESET_IDLES;
  localparam int WAKE_SLOT  = BURST_BITS + WAKE_IDLES;
  localparam int MAX_SLOT   = (RESET_SLOT > WAKE_SLOT) ? RESET_SLOT : WAKE_SLOT;
  localparam int POS_W      = $clog2(MAX_SLOT);
  localparam int MAX_BURSTS = (NUM_COMRESET > NUM_COMWAKE) ? NUM_COMRESET : NUM_COMWAKE;
  localparam int BST_W      = $clog2(MAX_BURSTS + 1);
  localparam int TO_W       = $clog2(TIMEOUT + 1);

  localparam logic [POS_W-1:0] RESET_SLOT_LAST = POS_W'(RESET_SLOT - 1);
  localparam logic [POS_W-1:0] WAKE_SLOT_LAST  = POS_W'(WAKE_SLOT - 1);
  localparam logic [POS_W-1:0] BURST_LEN       = POS_W'(BURST_BITS);
  localparam logic [BST_W-1:0] RESET_BURST_LAST = BST_W'(NUM_COMRESET - 1);
  localparam logic [BST_W-1:0] WAKE_BURST_LAST  = BST_W'(NUM_COMWAKE - 1);
  localparam logic [TO_W-1:0]  TIMEOUT_LAST     = TO_W'(TIMEOUT - 1);

  state_t             state;
  logic [POS_W-1:0]   pos;
  logic [5:0]         seq;
  logic [BST_W-1:0]   burst_cnt;
  logic [TO_W-1:0]    to_cnt;

  logic cominit_meta, cominit_s, cominit_q;
  logic comwake_meta, comwake_s;

  state_t             state_n;
  logic [POS_W-1:0]   pos_n;
  logic [5:0]         seq_n;
  logic [BST_W-1:0]   burst_n;
  logic [TO_W-1:0]    to_n;
  logic               retry_n;
  logic [3:0]         retries_n;
  logic               tx_n;
  logic               idle_n;
  logic               ready_n;
  logic               restart;
  logic               waiting;

  logic [POS_W-1:0]   slot_last;
  logic [BST_W-1:0]   burst_last;
  logic [5:0]         seq_inc;
  logic               timeout_hit;
  logic               cominit_fall;

  assign o_state = state;

  // Helper terms shared by the next-state logic. The slot and burst limits
  // depend on which of the two SEND states is running.
  always_comb begin
    slot_last    = (state == ST_SEND_COMRESET) ? RESET_SLOT_LAST : WAKE_SLOT_LAST;
    burst_last   = (state == ST_SEND_COMRESET) ? RESET_BURST_LAST : WAKE_BURST_LAST;
    seq_inc      = (seq == SEQ_LAST) ? 6'd0 : seq + 6'd1;
    timeout_hit  = (to_cnt == TIMEOUT_LAST);
    cominit_fall = cominit_q & ~cominit_s;
  end

  // Next-state and next-counter logic. A restart request overrides a timeout
  // and any detector transition in the same cycle. A restart request does not
  // count as a retry. Any state change, or a restart that re-enters
  // SEND_COMRESET, clears the burst position and the timeout counter.
  always_comb begin
    state_n   = state;
    pos_n     = pos;
    seq_n     = seq;
    burst_n   = burst_cnt;
    to_n      = to_cnt;
    retry_n   = 1'b0;
    retries_n = o_retries;
    restart   = 1'b0;
    waiting   = 1'b0;

    case (state)
      ST_IDLE: state_n = ST_SEND_COMRESET;
      ST_SEND_COMRESET, ST_SEND_COMWAKE: begin
        if (pos == slot_last) begin
          pos_n = '0;
          seq_n = '0;
          if (burst_cnt == burst_last) begin
            burst_n = '0;
            state_n = (state == ST_SEND_COMRESET) ? ST_WAIT_COMINIT : ST_WAIT_COMWAKE;
          end else begin
            burst_n = burst_cnt + BST_W'(1);
          end
        end else begin
          pos_n = pos + POS_W'(1);
          seq_n = seq_inc;
        end
      end
      ST_WAIT_COMINIT: begin
        waiting = 1'b1;
        if (cominit_fall) state_n = ST_SEND_COMWAKE;
      end
      ST_WAIT_COMWAKE: begin
        waiting = 1'b1;
        if (comwake_s) state_n = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        waiting = 1'b1;
        if (!comwake_s) state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (cominit_s) state_n = ST_SEND_COMRESET;
      end
      default: state_n = ST_IDLE;
    endcase

    // A detector transition in the same cycle wins over the timeout.
    if (waiting && (state_n == state)) begin
      if (timeout_hit) begin
        state_n   = ST_SEND_COMRESET;
        retry_n   = 1'b1;
        retries_n = (o_retries == 4'd15) ? o_retries : o_retries + 4'd1;
      end else begin
        to_n = to_cnt + TO_W'(1);
      end
    end

    if (i_comreset_req) begin
      state_n   = ST_SEND_COMRESET;
      retry_n   = 1'b0;
      retries_n = o_retries;
      restart   = 1'b1;
    end

    if (restart || (state_n != state)) begin
      pos_n   = '0;
      seq_n   = '0;
      burst_n = '0;
      to_n    = '0;
    end

    // Outputs come from the next state and next position. That way the first
    // burst bit is on the line in the first cycle of a SEND state.
    tx_n    = 1'b0;
    idle_n  = 1'b1;
    ready_n = 1'b0;
    case (state_n)
      ST_SEND_COMRESET, ST_SEND_COMWAKE: begin
        if (pos_n < BURST_LEN) begin
          tx_n   = COM_SEQ[SEQ_LAST - seq_n];
          idle_n = 1'b0;
        end
      end
      ST_ACTIVE: begin
        tx_n    = i_tx;
        idle_n  = 1'b0;
        ready_n = 1'b1;
      end
      default: begin
        tx_n    = 1'b0;
        idle_n  = 1'b1;
        ready_n = 1'b0;
      end
    endcase
  end

  // State, counters, detector synchronisers and registered outputs.
  // cominit_q holds the previous synchronised COMINIT value for fall detection.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_IDLE;
      pos          <= '0;
      seq          <= '0;
      burst_cnt    <= '0;
      to_cnt       <= '0;
      cominit_meta <= 1'b0;
      cominit_s    <= 1'b0;
      cominit_q    <= 1'b0;
      comwake_meta <= 1'b0;
      comwake_s    <= 1'b0;
      o_tx         <= 1'b0;
      o_tx_idle    <= 1'b1;
      o_link_ready <= 1'b0;
      o_retry      <= 1'b0;
      o_retries    <= 4'd0;
    end else begin
      state        <= state_n;
      pos          <= pos_n;
      seq          <= seq_n;
      burst_cnt    <= burst_n;
      to_cnt       <= to_n;
      cominit_meta <= i_cominit_det;
      cominit_s    <= cominit_meta;
      cominit_q    <= cominit_s;
      comwake_meta <= i_comwake_det;
      comwake_s    <= comwake_meta;
      o_tx         <= tx_n;
      o_tx_idle    <= idle_n;
      o_link_ready <= ready_n;
      o_retry      <= retry_n;
      o_retries    <= retries_n;
    end
  end

endmodule
